// File: rtl/hack_dmem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hack_dmem_pkg
// Description : Shared types and default geometry for the Hack data memory
//               map: controller state, address region and the default
//               RAM / screen / keyboard layout of the classic Hack machine.
// Revision    : 1.0 - initial release
// ============================================================================
package hack_dmem_pkg;

  // Controller state: CLEAR zeroes the storage, READY serves the CPU.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Result of decoding a CPU word address.
  typedef enum logic [1:0] {
    RGN_RAM    = 2'd0,
    RGN_SCREEN = 2'd1,
    RGN_KBD    = 2'd2,
    RGN_NONE   = 2'd3
  } region_t;

  // Default Hack memory layout.
  localparam int c_data_w       = 16;
  localparam int c_addr_w       = 15;
  localparam int c_ram_depth    = 16384;
  localparam int c_screen_base  = 16384;
  localparam int c_screen_depth = 8192;
  localparam int c_kbd_addr     = 24576;

endpackage : hack_dmem_pkg
`default_nettype wire

// File: rtl/hack_dmem_bank.sv
`default_nettype none
// ============================================================================
// Module      : hack_dmem_bank
// Description : Word array with one synchronous write port, one registered
//               read port (updates only when rd_en is high, otherwise holds)
//               and an optional second registered read port (PORT_B_EN).
//               Port B is read-first: a same-cycle write on port A returns
//               the old word. b_clr forces port B output to zero.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n          clock, async active-low reset
//               wr_en/wr_addr/wr_data   write port
//               rd_en/rd_addr/rd_data   registered read port
//               b_clr/b_addr/b_data     optional second read port
// ============================================================================
module hack_dmem_bank #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 16384,
  parameter int AW        = 14,
  parameter bit PORT_B_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             b_clr,
  input  logic [AW-1:0]    b_addr,
  output logic [WIDTH-1:0] b_data
);

  // Storage is never reset; the top-level clear sequencer zeroes it.
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

  generate
    if (PORT_B_EN) begin : g_port_b
      logic [WIDTH-1:0] r_b_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_b_data <= '0;
        end else if (b_clr) begin
          r_b_data <= '0;
        end else begin
          r_b_data <= r_mem[b_addr];
        end
      end

      assign b_data = r_b_data;
    end else begin : g_no_port_b
      logic w_unused_b;
      assign w_unused_b = &{1'b0, b_clr, b_addr};
      assign b_data     = '0;
    end
  endgenerate

endmodule : hack_dmem_bank
`default_nettype wire

// File: rtl/hack_data_memory_map.sv
`default_nettype none
// ============================================================================
// Module      : hack_data_memory_map
// Description : Memory-mapped Hack data space: general RAM, screen frame
//               buffer and keyboard register behind one request port.
//               After reset a clear sequencer zeroes RAM then screen, one
//               word per cycle, before req_ready rises. Reads are returned
//               one cycle after acceptance with a rd_valid pulse; accesses
//               to unmapped space (and keyboard writes) pulse addr_err.
// Revision    : 1.0 - initial release
// Config      : HACK_DMEM_SCREEN_PORT_EN adds the display read port
//               (scr_addr / scr_data).
// Ports       : clk, rst_n            clock, async active-low reset
//               req_valid, req_ready  request handshake
//               write_en, address, data_in   request payload
//               rd_valid, data_out    read response
//               addr_err              unmapped / illegal access pulse
//               init_done             clear sequence complete
//               kbd_code              asynchronous keyboard scan code
//               scr_addr, scr_data    display read port (optional)
// ============================================================================
module hack_data_memory_map
  import hack_dmem_pkg::*;
#(
  parameter int DATA_W       = c_data_w,
  parameter int ADDR_W       = c_addr_w,
  parameter int RAM_DEPTH    = c_ram_depth,
  parameter int SCREEN_BASE  = c_screen_base,
  parameter int SCREEN_DEPTH = c_screen_depth,
  parameter int KBD_ADDR     = c_kbd_addr
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            write_en,
  input  logic [ADDR_W-1:0]               address,
  input  logic [DATA_W-1:0]               data_in,
  output logic                            rd_valid,
  output logic [DATA_W-1:0]               data_out,
  output logic                            addr_err,
  output logic                            init_done,
  input  logic [DATA_W-1:0]               kbd_code
`ifdef HACK_DMEM_SCREEN_PORT_EN
  ,
  input  logic [$clog2(SCREEN_DEPTH)-1:0] scr_addr,
  output logic [DATA_W-1:0]               scr_data
`endif
);

  localparam int c_ram_aw = $clog2(RAM_DEPTH);
  localparam int c_scr_aw = $clog2(SCREEN_DEPTH);
  localparam int c_clr_n  = RAM_DEPTH + SCREEN_DEPTH;
  localparam int c_clr_w  = $clog2(c_clr_n);
  localparam logic [c_clr_w-1:0] c_clr_last = c_clr_w'(c_clr_n - 1);
`ifdef HACK_DMEM_SCREEN_PORT_EN
  localparam bit c_scr_port_b = 1'b1;
`else
  localparam bit c_scr_port_b = 1'b0;
`endif

  state_t                r_state;
  logic [c_clr_w-1:0]    r_clr_cnt;
  logic                  r_req_ready;
  logic                  r_init_done;
  logic                  r_rd_valid;
  logic                  r_addr_err;
  region_t               r_rd_rgn;
  logic [DATA_W-1:0]     r_kbd_s1;
  logic [DATA_W-1:0]     r_kbd_s2;
  logic [DATA_W-1:0]     r_kbd_q;

  logic                  w_accept;
  logic                  w_clearing;
  logic                  w_clr_in_ram;
  logic [31:0]           w_addr_ext;
  region_t               w_rgn;
  logic [c_ram_aw-1:0]   w_ram_idx;
  logic [c_scr_aw-1:0]   w_scr_idx;
  logic                  w_cpu_rd;
  logic                  w_cpu_wr;

  logic                  w_ram_we;
  logic [c_ram_aw-1:0]   w_ram_waddr;
  logic [DATA_W-1:0]     w_ram_q;
  logic                  w_scr_we;
  logic [c_scr_aw-1:0]   w_scr_waddr;
  logic [DATA_W-1:0]     w_scr_q;
  logic [DATA_W-1:0]     w_wdata;
  logic [c_scr_aw-1:0]   w_scr_b_addr;
  logic [DATA_W-1:0]     w_unused_ram_b;
  logic [DATA_W-1:0]     w_scr_b_data;

  // --------------------------------------------------------------------------
  // Address decode (RAM takes priority over an overlapping screen window)
  // --------------------------------------------------------------------------
  assign w_addr_ext = 32'(address);

  always_comb begin
    w_rgn = RGN_NONE;
    if (w_addr_ext < 32'(RAM_DEPTH)) begin
      w_rgn = RGN_RAM;
    end else if ((w_addr_ext >= 32'(SCREEN_BASE)) &&
                 (w_addr_ext <  32'(SCREEN_BASE + SCREEN_DEPTH))) begin
      w_rgn = RGN_SCREEN;
    end else if (w_addr_ext == 32'(KBD_ADDR)) begin
      w_rgn = RGN_KBD;
    end
  end

  assign w_ram_idx = c_ram_aw'(address);
  assign w_scr_idx = c_scr_aw'(address - ADDR_W'(SCREEN_BASE));

  // req_ready is only ever high in READY, so this also gates off CLEAR.
  assign w_accept = req_valid && r_req_ready;
  assign w_cpu_rd = w_accept && !write_en;
  assign w_cpu_wr = w_accept &&  write_en;

  // --------------------------------------------------------------------------
  // Bank write muxing: the clear sequencer owns the write ports in CLEAR.
  // clr_cnt walks RAM first, then the screen words that follow it.
  // --------------------------------------------------------------------------
  assign w_clearing   = (r_state == CLEAR);
  assign w_clr_in_ram = (r_clr_cnt < c_clr_w'(RAM_DEPTH));
  assign w_wdata      = w_clearing ? '0 : data_in;

  assign w_ram_we    = w_clearing ? w_clr_in_ram
                                  : (w_cpu_wr && (w_rgn == RGN_RAM));
  assign w_ram_waddr = w_clearing ? c_ram_aw'(r_clr_cnt) : w_ram_idx;

  assign w_scr_we    = w_clearing ? !w_clr_in_ram
                                  : (w_cpu_wr && (w_rgn == RGN_SCREEN));
  assign w_scr_waddr = w_clearing ? c_scr_aw'(r_clr_cnt - c_clr_w'(RAM_DEPTH))
                                  : w_scr_idx;

`ifdef HACK_DMEM_SCREEN_PORT_EN
  assign w_scr_b_addr = scr_addr;
  assign scr_data     = w_scr_b_data;
`else
  logic [DATA_W-1:0] w_unused_scr_b;
  assign w_scr_b_addr   = '0;
  assign w_unused_scr_b = w_scr_b_data;
`endif

  hack_dmem_bank #(
    .WIDTH     (DATA_W),
    .DEPTH     (RAM_DEPTH),
    .AW        (c_ram_aw),
    .PORT_B_EN (1'b0)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_ram_we),
    .wr_addr (w_ram_waddr),
    .wr_data (w_wdata),
    .rd_en   (w_cpu_rd && (w_rgn == RGN_RAM)),
    .rd_addr (w_ram_idx),
    .rd_data (w_ram_q),
    .b_clr   (1'b0),
    .b_addr  ('0),
    .b_data  (w_unused_ram_b)
  );

  hack_dmem_bank #(
    .WIDTH     (DATA_W),
    .DEPTH     (SCREEN_DEPTH),
    .AW        (c_scr_aw),
    .PORT_B_EN (c_scr_port_b)
  ) u_screen (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_scr_we),
    .wr_addr (w_scr_waddr),
    .wr_data (w_wdata),
    .rd_en   (w_cpu_rd && (w_rgn == RGN_SCREEN)),
    .rd_addr (w_scr_idx),
    .rd_data (w_scr_q),
    .b_clr   (w_clearing),
    .b_addr  (w_scr_b_addr),
    .b_data  (w_scr_b_data)
  );

  // --------------------------------------------------------------------------
  // Keyboard synchroniser
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kbd_s1 <= '0;
      r_kbd_s2 <= '0;
    end else begin
      r_kbd_s1 <= kbd_code;
      r_kbd_s2 <= r_kbd_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Controller: clear sequencer and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CLEAR;
      r_clr_cnt   <= '0;
      r_req_ready <= 1'b0;
      r_init_done <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_addr_err  <= 1'b0;
      r_rd_rgn    <= RGN_NONE;
      r_kbd_q     <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_rd_valid <= 1'b0;
          r_addr_err <= 1'b0;
          if (r_clr_cnt == c_clr_last) begin
            r_state     <= READY;
            r_req_ready <= 1'b1;
            r_init_done <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + c_clr_w'(1);
          end
        end
        READY: begin
          r_rd_valid <= w_cpu_rd;
          r_addr_err <= w_accept &&
                        ((w_rgn == RGN_NONE) || ((w_rgn == RGN_KBD) && write_en));
          // The region of the last read selects which holding register
          // drives data_out, so data_out holds between reads.
          if (w_cpu_rd) begin
            r_rd_rgn <= w_rgn;
            if (w_rgn == RGN_KBD) begin
              r_kbd_q <= r_kbd_s2;
            end
          end
        end
        default: begin
          r_state <= CLEAR;
        end
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    case (r_rd_rgn)
      RGN_RAM:    data_out = w_ram_q;
      RGN_SCREEN: data_out = w_scr_q;
      RGN_KBD:    data_out = r_kbd_q;
      default:    data_out = '0;
    endcase
  end

  assign req_ready = r_req_ready;
  assign init_done = r_init_done;
  assign rd_valid  = r_rd_valid;
  assign addr_err  = r_addr_err;

endmodule : hack_data_memory_map
`default_nettype wire

// File: tb/tb_hack_data_memory_map.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_data_memory_map
// Description : Self-checking bench for hack_data_memory_map in the small
//               build (16 RAM words, 8 screen words at 16, keyboard at 24).
//               A behavioural model of the memory map tracks the expected
//               outputs and is compared against the DUT every cycle; a few
//               directed scenarios pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_data_memory_map;

  localparam int DW   = 16;
  localparam int AW   = 15;
  localparam int RD   = 16;
  localparam int SB   = 16;
  localparam int SD   = 8;
  localparam int KA   = 24;
  localparam int NCLR = RD + SD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          write_en;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] kbd_code;
  logic          req_ready;
  logic          rd_valid;
  logic [DW-1:0] data_out;
  logic          addr_err;
  logic          init_done;
`ifdef HACK_DMEM_SCREEN_PORT_EN
  logic [2:0]    scr_addr;
  logic [DW-1:0] scr_data;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hack_data_memory_map #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .RAM_DEPTH    (RD),
    .SCREEN_BASE  (SB),
    .SCREEN_DEPTH (SD),
    .KBD_ADDR     (KA)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .write_en  (write_en),
    .address   (address),
    .data_in   (data_in),
    .rd_valid  (rd_valid),
    .data_out  (data_out),
    .addr_err  (addr_err),
    .init_done (init_done),
    .kbd_code  (kbd_code)
`ifdef HACK_DMEM_SCREEN_PORT_EN
    ,
    .scr_addr  (scr_addr),
    .scr_data  (scr_data)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: word arrays per region, a 2-deep delay line for the
  // keyboard and a count of cycles spent clearing.
  // --------------------------------------------------------------------------
  logic [DW-1:0] m_ram [RD];
  logic [DW-1:0] m_scr [SD];
  logic [DW-1:0] m_kh1 = '0, m_kh2 = '0;
  int            m_cnt = 0;
  int            m_a;
  bit            m_ready = 1'b0;
  logic          e_rd_valid = 1'b0, e_addr_err = 1'b0;
  logic [DW-1:0] e_data = '0, e_scr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 1'b0; m_cnt = 0; m_kh1 = '0; m_kh2 = '0;
      e_rd_valid = 1'b0; e_addr_err = 1'b0; e_data = '0; e_scr = '0;
      // Storage will be fully re-zeroed before it can be observed again.
      for (int i = 0; i < RD; i++) m_ram[i] = '0;
      for (int i = 0; i < SD; i++) m_scr[i] = '0;
    end else begin
      e_rd_valid = 1'b0;
      e_addr_err = 1'b0;
`ifdef HACK_DMEM_SCREEN_PORT_EN
      e_scr = m_ready ? m_scr[scr_addr] : '0;
`endif
      if (!m_ready) begin
        m_cnt++;
        if (m_cnt == NCLR) m_ready = 1'b1;
      end else if (req_valid) begin
        m_a = int'(address);
        if (m_a < RD) begin
          if (write_en) m_ram[m_a] = data_in;
          else begin e_rd_valid = 1'b1; e_data = m_ram[m_a]; end
        end else if (m_a >= SB && m_a < SB + SD) begin
          if (write_en) m_scr[m_a - SB] = data_in;
          else begin e_rd_valid = 1'b1; e_data = m_scr[m_a - SB]; end
        end else if (m_a == KA) begin
          if (write_en) e_addr_err = 1'b1;
          else begin e_rd_valid = 1'b1; e_data = m_kh2; end
        end else begin
          e_addr_err = 1'b1;
          if (!write_en) begin e_rd_valid = 1'b1; e_data = '0; end
        end
      end
      m_kh2 = m_kh1;
      m_kh1 = kbd_code;
    end
  end

  // Continuous comparison, away from the active edge.
  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(m_ready));
    chk("init_done", 32'(init_done), 32'(m_ready));
    chk("rd_valid",  32'(rd_valid),  32'(e_rd_valid));
    chk("addr_err",  32'(addr_err),  32'(e_addr_err));
    chk("data_out",  32'(data_out),  32'(e_data));
`ifdef HACK_DMEM_SCREEN_PORT_EN
    chk("scr_data",  32'(scr_data),  32'(e_scr));
`endif
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers; each is entered and left 2 time units after a posedge.
  // --------------------------------------------------------------------------
  task automatic idle();
    req_valid = 1'b0;
    write_en  = 1'b0;
  endtask

  task automatic cpu_write(input int addr, input logic [DW-1:0] data);
    req_valid = 1'b1; write_en = 1'b1; address = AW'(addr); data_in = data;
    @(posedge clk); #2;
    idle();
  endtask

  task automatic cpu_read_chk(input string name, input int addr,
                              input logic [DW-1:0] exp, input logic exp_err);
    req_valid = 1'b1; write_en = 1'b0; address = AW'(addr);
    @(posedge clk); #1;
    chk({name, " rd_valid"}, 32'(rd_valid), 32'd1);
    chk({name, " data"},     32'(data_out), 32'(exp));
    chk({name, " addr_err"}, 32'(addr_err), 32'(exp_err));
    #1 idle();
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    for (int i = 1; i <= NCLR + 20; i++) begin
      @(posedge clk); #1;
      if (req_ready) begin k = i; break; end
    end
    chk({name, " clear cycles"}, 32'(k), 32'(NCLR));
    #1 idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    req_valid = 1'b0; write_en = 1'b0; address = '0; data_in = '0; kbd_code = '0;
`ifdef HACK_DMEM_SCREEN_PORT_EN
    scr_addr = '0;
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset init_done", 32'(init_done), 32'd0);
    chk("reset rd_valid",  32'(rd_valid),  32'd0);
    chk("reset data_out",  32'(data_out),  32'd0);

    // Requests during CLEAR must be ignored.
    req_valid = 1'b1; write_en = 1'b0; address = AW'(2);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("initial");

    // Freshly cleared space reads as zero.
    cpu_read_chk("clr ram0",  0,  16'h0000, 1'b0);
    cpu_read_chk("clr ram15", 15, 16'h0000, 1'b0);
    cpu_read_chk("clr scr16", 16, 16'h0000, 1'b0);
    cpu_read_chk("clr scr23", 23, 16'h0000, 1'b0);

    cpu_write(5, 16'h1234);
    cpu_read_chk("ram5", 5, 16'h1234, 1'b0);

    cpu_write(20, 16'hBEEF);
    cpu_read_chk("scr20", 20, 16'hBEEF, 1'b0);
`ifdef HACK_DMEM_SCREEN_PORT_EN
    scr_addr = 3'd4;
    @(posedge clk); #1;
    chk("scr port 4", 32'(scr_data), 32'h0000BEEF);
    #1;
`endif

    kbd_code = 16'h0041;
    repeat (3) @(posedge clk);
    #2;
    cpu_read_chk("kbd", 24, 16'h0041, 1'b0);
    req_valid = 1'b1; write_en = 1'b1; address = AW'(24); data_in = 16'hFFFF;
    @(posedge clk); #1;
    chk("kbd write addr_err", 32'(addr_err), 32'd1);
    chk("kbd write rd_valid", 32'(rd_valid), 32'd0);
    #1 idle();
    cpu_read_chk("kbd reread", 24, 16'h0041, 1'b0);

    cpu_read_chk("unmapped30", 30, 16'h0000, 1'b1);

    // Randomised back-to-back traffic checked by the model.
    for (int n = 0; n < 500; n++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      write_en  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) address = AW'($urandom);
      else                           address = AW'($urandom_range(0, 31));
      data_in = DW'($urandom);
      if ($urandom_range(0, 1) == 1) kbd_code = DW'($urandom);
`ifdef HACK_DMEM_SCREEN_PORT_EN
      scr_addr = 3'($urandom_range(0, 7));
`endif
      @(posedge clk); #2;
    end
    idle();

    // Reset while a read is in flight.
    cpu_write(3, 16'h5555);
    req_valid = 1'b1; write_en = 1'b0; address = AW'(3);
    #2 rst_n = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst rd_valid",  32'(rd_valid),  32'd0);
      chk("midrst req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("after reset");
    cpu_read_chk("ram3 recleared", 3, 16'h0000, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_hack_data_memory_map
`default_nettype wire
